serial_subtractor_16bit: RTL and testbench

SERIAL_SUBTRACTOR_16BIT -- requirements
Module: serial_subtractor_16bit

---
 rtl/serial_subtractor_16bit.sv | 170 +++++++++++++++++
 tb/tb_serial_subtractor_16bit.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_16bit.sv
// ---------------------------------------------------------------------------
// serial_subtractor_16bit
//
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// using a single full-subtractor cell and shift registers. An operation is
// accepted from IDLE, runs for WIDTH cycles in RUN, then presents a one-cycle
// done pulse in DONE before returning to IDLE.
//
// Ports
//   clk    in   clock, all state changes on the rising edge
//   rst    in   asynchronous active-high reset
//   start  in   request a subtraction (honoured only in IDLE)
//   a      in   minuend, captured on the accepting edge
//   b      in   subtrahend, captured on the accepting edge
//   bin    in   borrow-in, captured on the accepting edge
//   busy   out  high while the operation is being computed (RUN)
//   done   out  one-cycle pulse when diff/bout/ovf carry a new result
//   diff   out  a - b - bin modulo 2^WIDTH, held until the next result
//   bout   out  borrow-out (unsigned a < b + bin), held with diff
//   ovf    out  two's-complement overflow of the subtraction, held with diff
// ---------------------------------------------------------------------------
module serial_subtractor_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    // One extra counter bit so the count can reach WIDTH without wrapping.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] minuend_q, minuend_d;
    logic [WIDTH-1:0] subtrahend_q, subtrahend_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             diffBit;
    logic             borrowNext;
    logic             lastBit;
    logic [WIDTH-1:0] resultNext;

    // State register: reset drops straight back to IDLE, abandoning any
    // operation in flight without producing a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start only matters in IDLE; DONE always lasts one
    // cycle, so start is never queued behind a running operation.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (lastBit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Full-subtractor cell on the current LSBs of the operand shift
    // registers. The new result bit enters at the MSB, so after WIDTH shifts
    // the result register holds the difference in natural bit order.
    always_comb begin
        diffBit    = minuend_q[0] ^ subtrahend_q[0] ^ borrow_q;
        borrowNext = (~minuend_q[0] & subtrahend_q[0])
                   | (~minuend_q[0] & borrow_q)
                   | (subtrahend_q[0] & borrow_q);
        resultNext = {diffBit, result_q[WIDTH-1:1]};
        lastBit    = (count_q == CNT_W'(WIDTH - 1));
    end

    // Datapath next-state. On the last bit, the operand LSBs are the
    // original sign bits, which is all the overflow rule needs, so no
    // separate copy of the operand MSBs is kept.
    always_comb begin
        minuend_d    = minuend_q;
        subtrahend_d = subtrahend_q;
        result_d     = result_q;
        borrow_d     = borrow_q;
        count_d      = count_q;
        diff_d       = diff_q;
        bout_d       = bout_q;
        ovf_d        = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    minuend_d    = a;
                    subtrahend_d = b;
                    borrow_d     = bin;
                    result_d     = '0;
                    count_d      = '0;
                end
            end
            RUN: begin
                minuend_d    = minuend_q >> 1;
                subtrahend_d = subtrahend_q >> 1;
                borrow_d     = borrowNext;
                result_d     = resultNext;
                count_d      = count_q + CNT_W'(1);
                if (lastBit) begin
                    diff_d = resultNext;
                    bout_d = borrowNext;
                    ovf_d  = (minuend_q[0] != subtrahend_q[0])
                           && (diffBit != minuend_q[0]);
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers: everything, including the visible result, is
    // cleared by reset without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            minuend_q    <= '0;
            subtrahend_q <= '0;
            result_q     <= '0;
            borrow_q     <= 1'b0;
            count_q      <= '0;
            diff_q       <= '0;
            bout_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            minuend_q    <= minuend_d;
            subtrahend_q <= subtrahend_d;
            result_q     <= result_d;
            borrow_q     <= borrow_d;
            count_q      <= count_d;
            diff_q       <= diff_d;
            bout_q       <= bout_d;
            ovf_q        <= ovf_d;
        end
    end

    // Outputs: status decoded from the state register, results straight
    // from their holding registers, so nothing combinational reaches a port.
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        diff = diff_q;
        bout = bout_q;
        ovf  = ovf_q;
    end

endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor_16bit
//
// Self-checking bench for serial_subtractor_16bit. Expected results come
// from plain integer arithmetic on the operands (unsigned and signed views),
// not from any bit-serial formulation.
// ---------------------------------------------------------------------------
module tb_serial_subtractor_16bit;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    int vectorCount = 0;
    int missCount   = 0;

    logic [WIDTH-1:0] obsDiff;
    logic             obsBout;
    logic             obsOvf;
    int               obsBusyCycles;
    int               obsLatency;
    bit               obsTimeout;
    bit               obsHeldBad;
    logic             obsDoneAfter;
    logic             obsBusyAfter;

    // Last result the design should be holding: {ovf, bout, diff}.
    logic [WIDTH+1:0] expPrev;

    serial_subtractor_16bit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Reference: returns {ovf, bout, diff} for a - b - bin.
    function automatic logic [WIDTH+1:0] refSub(input logic [WIDTH-1:0] av,
                                                input logic [WIDTH-1:0] bv,
                                                input logic bi);
        int ua, ub, sa, sb, sr;
        logic [WIDTH-1:0] d;
        logic bo, ov;
        ua = int'(av);
        ub = int'(bv);
        sa = int'($signed(av));
        sb = int'($signed(bv));
        d  = WIDTH'(ua - ub - int'(bi));
        bo = (ua < ub + int'(bi));
        sr = sa - sb - int'(bi);
        ov = (sr > 32767) || (sr < -32768);
        return {ov, bo, d};
    endfunction

    // Drives one operation starting just after a falling edge and observes
    // it until one cycle past done. During RUN it wiggles start and the
    // operands (must be ignored); on the done cycle it asserts start with
    // junk operands (must be ignored in DONE). Results land in obs*.
    task automatic applyStimulus(input logic [WIDTH-1:0] av,
                                 input logic [WIDTH-1:0] bv,
                                 input logic bi);
        bit seen;
        start = 1'b1;
        a = av;
        b = bv;
        bin = bi;
        seen = 1'b0;
        obsTimeout = 1'b0;
        obsHeldBad = 1'b0;
        obsBusyCycles = 0;
        obsLatency = 0;
        obsDoneAfter = 1'b0;
        obsBusyAfter = 1'b0;
        @(posedge clk);
        for (int j = 1; j <= 40 && !seen; j++) begin
            @(negedge clk);
            if (busy === 1'b1) obsBusyCycles++;
            if (done === 1'b1) begin
                seen = 1'b1;
                obsLatency = j;
                obsDiff = diff;
                obsBout = bout;
                obsOvf = ovf;
                start = 1'b1;
            end else begin
                if ({ovf, bout, diff} !== expPrev) obsHeldBad = 1'b1;
                start = 1'($urandom);
            end
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            bin = 1'($urandom);
        end
        if (!seen) begin
            obsTimeout = 1'b1;
            start = 1'b0;
        end else begin
            @(negedge clk);
            obsDoneAfter = done;
            obsBusyAfter = busy;
            start = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        expPrev = '0;
        repeat (3) @(negedge clk);
        vectorCount++;
        if ({busy, done} !== 2'b00) begin
            missCount++;
            $display("[TB] FAIL reset_status busy/done=%b required 00", {busy, done});
        end
        vectorCount++;
        if ({ovf, bout, diff} !== '0) begin
            missCount++;
            $display("[TB] FAIL reset_result ovf/bout/diff=%h required 0", {ovf, bout, diff});
        end
        // Released on a falling edge so the next edge can accept a start.
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] ta [6] = '{16'h1234, 16'h0000, 16'h8000, 16'h7FFF, 16'h0005, 16'h0000};
        logic [WIDTH-1:0] tb [6] = '{16'h0234, 16'h0001, 16'h0001, 16'hFFFF, 16'h0003, 16'h0000};
        logic             tc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [WIDTH+1:0] te [6] = '{{2'b00, 16'h1000}, {2'b01, 16'hFFFF}, {2'b10, 16'h7FFF},
                                    {2'b11, 16'h8000}, {2'b00, 16'h0001}, {2'b01, 16'hFFFF}};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(ta[i], tb[i], tc[i]);
            vectorCount++;
            if (obsTimeout || {obsOvf, obsBout, obsDiff} !== te[i]) begin
                missCount++;
                $display("[TB] FAIL directed_%0d ovf/bout/diff=%b/%b/%h required %b/%b/%h timeout=%0d",
                         i, obsOvf, obsBout, obsDiff, te[i][17], te[i][16], te[i][15:0], obsTimeout);
            end
            vectorCount++;
            if (obsBusyCycles != WIDTH || obsLatency != WIDTH + 1) begin
                missCount++;
                $display("[TB] FAIL directed_timing_%0d busy cycles=%0d latency=%0d required %0d/%0d",
                         i, obsBusyCycles, obsLatency, WIDTH, WIDTH + 1);
            end
            expPrev = te[i];
        end
    endtask

    task automatic test_back_to_back_random();
        logic [WIDTH-1:0] corner [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
        logic [WIDTH-1:0] av, bv;
        logic             bi;
        logic [WIDTH+1:0] exp;
        for (int i = 0; i < 40; i++) begin
            av = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : WIDTH'($urandom);
            bv = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : WIDTH'($urandom);
            bi = 1'($urandom);
            exp = refSub(av, bv, bi);
            applyStimulus(av, bv, bi);
            vectorCount++;
            if (obsTimeout !== 1'b0) begin
                missCount++;
                $display("[TB] FAIL rand_timeout_%0d no done within budget, required done", i);
            end
            vectorCount++;
            if (obsDiff !== exp[15:0]) begin
                missCount++;
                $display("[TB] FAIL rand_diff_%0d a=%h b=%h bin=%b diff=%h required %h",
                         i, av, bv, bi, obsDiff, exp[15:0]);
            end
            vectorCount++;
            if (obsBout !== exp[16]) begin
                missCount++;
                $display("[TB] FAIL rand_bout_%0d a=%h b=%h bin=%b bout=%b required %b",
                         i, av, bv, bi, obsBout, exp[16]);
            end
            vectorCount++;
            if (obsOvf !== exp[17]) begin
                missCount++;
                $display("[TB] FAIL rand_ovf_%0d a=%h b=%h bin=%b ovf=%b required %b",
                         i, av, bv, bi, obsOvf, exp[17]);
            end
            vectorCount++;
            if (obsLatency != WIDTH + 1 || obsBusyCycles != WIDTH) begin
                missCount++;
                $display("[TB] FAIL rand_timing_%0d latency=%0d busy cycles=%0d required %0d/%0d",
                         i, obsLatency, obsBusyCycles, WIDTH + 1, WIDTH);
            end
            vectorCount++;
            if (obsDoneAfter !== 1'b0 || obsBusyAfter !== 1'b0) begin
                missCount++;
                $display("[TB] FAIL rand_after_done_%0d done/busy=%b%b required 00",
                         i, obsDoneAfter, obsBusyAfter);
            end
            vectorCount++;
            if (obsHeldBad !== 1'b0) begin
                missCount++;
                $display("[TB] FAIL rand_hold_%0d outputs changed during run, required held %h",
                         i, expPrev);
            end
            expPrev = exp;
        end
    endtask

    task automatic test_start_held();
        logic [WIDTH-1:0] a1, b1, a2, b2;
        logic             c1, c2;
        logic [WIDTH+1:0] e1, e2, got1, got2;
        int               doneCount, riseAt;
        logic             prevBusy;
        a1 = WIDTH'($urandom);
        b1 = WIDTH'($urandom);
        c1 = 1'($urandom);
        a2 = '0;
        b2 = '0;
        c2 = 1'b0;
        got1 = '0;
        got2 = '0;
        doneCount = 0;
        riseAt = 0;
        prevBusy = 1'b1;
        start = 1'b1;
        a = a1;
        b = b1;
        bin = c1;
        @(posedge clk);
        for (int j = 1; j <= 45 && doneCount < 2; j++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (doneCount == 0) got1 = {ovf, bout, diff};
                else got2 = {ovf, bout, diff};
                doneCount++;
            end
            if (busy === 1'b1 && prevBusy === 1'b0 && riseAt == 0) begin
                riseAt = j;
                start = 1'b0;
            end
            prevBusy = busy;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            bin = 1'($urandom);
            // Remember what the next edge would capture if it accepts.
            if (riseAt == 0) begin
                a2 = a;
                b2 = b;
                c2 = bin;
            end
        end
        start = 1'b0;
        e1 = refSub(a1, b1, c1);
        e2 = refSub(a2, b2, c2);
        vectorCount++;
        if (got1 !== e1) begin
            missCount++;
            $display("[TB] FAIL held_first_result got=%h required %h", got1, e1);
        end
        vectorCount++;
        if (riseAt - 1 != WIDTH + 2) begin
            missCount++;
            $display("[TB] FAIL held_reaccept_spacing=%0d required %0d", riseAt - 1, WIDTH + 2);
        end
        vectorCount++;
        if (doneCount != 2 || got2 !== e2) begin
            missCount++;
            $display("[TB] FAIL held_second_result got=%h dones=%0d required %h dones=2",
                     got2, doneCount, e2);
        end
        @(negedge clk);
        expPrev = e2;
    endtask

    task automatic test_reset_mid_run();
        logic [WIDTH+1:0] exp;
        bit               sawDone;
        // Leave every result output nonzero so the reset clear is visible.
        applyStimulus(16'h7FFF, 16'hFFFF, 1'b0);
        expPrev = {2'b11, 16'h8000};
        start = 1'b1;
        a = 16'h4321;
        b = 16'h1111;
        bin = 1'b0;
        @(posedge clk);
        sawDone = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) sawDone = 1'b1;
        end
        #2 rst = 1'b1;
        #1;
        vectorCount++;
        if ({busy, done, ovf, bout, diff} !== '0) begin
            missCount++;
            $display("[TB] FAIL midrun_async_clear busy/done/ovf/bout/diff=%b%b%b%b/%h required all 0",
                     busy, done, ovf, bout, diff);
        end
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) sawDone = 1'b1;
        end
        vectorCount++;
        if (sawDone) begin
            missCount++;
            $display("[TB] FAIL midrun_no_done activity seen=1 required 0");
        end
        rst = 1'b0;
        expPrev = '0;
        exp = refSub(16'hA5A5, 16'h5A5B, 1'b1);
        applyStimulus(16'hA5A5, 16'h5A5B, 1'b1);
        vectorCount++;
        if (obsTimeout || {obsOvf, obsBout, obsDiff} !== exp || obsLatency != WIDTH + 1) begin
            missCount++;
            $display("[TB] FAIL midrun_restart got=%h latency=%0d required %h latency=%0d",
                     {obsOvf, obsBout, obsDiff}, obsLatency, exp, WIDTH + 1);
        end
        expPrev = exp;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back_random();
        test_start_held();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
